// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extract/extend, result mux, x0 suppression, misaligned-load flag, retire counter
module writeback_stage #(
  parameter int P_WIDTH     = 32,
  parameter int P_PC_WIDTH  = 10,
  parameter int P_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid_m,
  input  logic [P_WIDTH-1:0]     i_alu_result_m,
  input  logic [P_WIDTH-1:0]     i_mem_data_m,
  input  logic [P_PC_WIDTH-1:0]  i_pc_plus_4_m,
  input  logic [P_WIDTH-1:0]     i_imm_m,
  input  logic [1:0]             i_resultsrc_m,
  input  logic [2:0]             i_funct3_m,
  input  logic [4:0]             i_rd_m,
  input  logic                   i_regwrite_m,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic                   o_valid_w,
  output logic                   o_regwrite_w,
  output logic [4:0]             o_rd_w,
  output logic [P_WIDTH-1:0]     o_result_w,
  output logic                   o_misaligned_w,
  output logic [P_CNT_WIDTH-1:0] o_instret
);
  localparam int OW = $clog2(P_WIDTH / 8);
  logic                   valid_q, rw_q;
  logic [P_WIDTH-1:0]     alu_q, mem_q, imm_q;
  logic [P_PC_WIDTH-1:0]  pc_q;
  logic [1:0]             src_q;
  logic [2:0]             f3_q;
  logic [4:0]             rd_q;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OW-1:0]          off;
  logic [P_WIDTH-1:0]     sh_b, sh_h, sh_w, load_v;
  logic                   is_h, is_w, is_d, mis, retire;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      src_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (i_flush) begin
        valid_q <= 1'b0;
      end else if (!i_stall) begin
        valid_q <= i_valid_m;
        alu_q   <= i_alu_result_m;
        mem_q   <= i_mem_data_m;
        pc_q    <= i_pc_plus_4_m;
        imm_q   <= i_imm_m;
        src_q   <= i_resultsrc_m;
        f3_q    <= i_funct3_m;
        rd_q    <= i_rd_m;
        rw_q    <= i_regwrite_m;
      end
    end
  end
  always_comb begin
    off    = alu_q[OW-1:0];
    sh_b   = mem_q >> {off, 3'b000};
    sh_h   = mem_q >> {off[OW-1:1], 4'b0000};
    sh_w   = (P_WIDTH == 64) ? mem_q >> {alu_q[2], 5'b00000} : mem_q;
    // unlisted encodings (and LD) pass the raw word through
    load_v = (f3_q == 3'b000) ? P_WIDTH'(signed'(sh_b[7:0])) :
             (f3_q == 3'b001) ? P_WIDTH'(signed'(sh_h[15:0])) :
             (f3_q == 3'b010) ? P_WIDTH'(signed'(sh_w[31:0])) :
             (f3_q == 3'b100) ? P_WIDTH'(sh_b[7:0]) :
             (f3_q == 3'b101) ? P_WIDTH'(sh_h[15:0]) :
             (f3_q == 3'b110 && P_WIDTH == 64) ? P_WIDTH'(sh_w[31:0]) : mem_q;
    is_h   = f3_q[1:0] == 2'b01;
    is_w   = f3_q == 3'b010 || (P_WIDTH == 64 && f3_q == 3'b110);
    is_d   = P_WIDTH == 64 && f3_q == 3'b011;
    mis    = valid_q && src_q == 2'b01 &&
             ((is_h && alu_q[0]) || (is_w && |alu_q[1:0]) || (is_d && |alu_q[2:0]));
    retire = valid_q && !i_stall && !i_flush && !mis;
    cnt_d  = retire ? cnt_q + P_CNT_WIDTH'(1) : cnt_q;
    o_result_w     = (src_q == 2'b00) ? alu_q :
                     (src_q == 2'b01) ? load_v :
                     (src_q == 2'b10) ? P_WIDTH'(pc_q) : imm_q;
    o_misaligned_w = mis;
    o_regwrite_w   = valid_q && rw_q && rd_q != 5'd0 && !mis;
    o_rd_w         = rd_q;
    o_valid_w      = valid_q;
    o_instret      = cnt_q;
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table vectors, corner sequences and random traffic against a reference model, on 32- and 64-bit instances
module tb_writeback_stage;
  typedef struct {
    logic [63:0] alu, mem, pc, imm;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
  } op_t;
  typedef struct {
    int          d;
    op_t         op;
    logic [63:0] res;
    logic        mis;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 0, rw0 = 0, st0 = 0, fl0 = 0;
  logic [31:0] alu0 = 0, mem0 = 0, imm0 = 0;
  logic [9:0]  pc0 = 0;
  logic [1:0]  src0 = 0;
  logic [2:0]  f30 = 0;
  logic [4:0]  rd0 = 0;
  logic        ov0, orw0, omis0;
  logic [4:0]  ord0;
  logic [31:0] ores0, ocnt0;

  logic        v1 = 0, rw1 = 0, st1 = 0, fl1 = 0;
  logic [63:0] alu1 = 0, mem1 = 0, imm1 = 0;
  logic [9:0]  pc1 = 0;
  logic [1:0]  src1 = 0;
  logic [2:0]  f31 = 0;
  logic [4:0]  rd1 = 0;
  logic        ov1, orw1, omis1;
  logic [4:0]  ord1;
  logic [63:0] ores1;
  logic [2:0]  ocnt1;

  writeback_stage #(.P_WIDTH(32), .P_PC_WIDTH(10), .P_CNT_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_m(v0), .i_alu_result_m(alu0),
    .i_mem_data_m(mem0), .i_pc_plus_4_m(pc0), .i_imm_m(imm0), .i_resultsrc_m(src0),
    .i_funct3_m(f30), .i_rd_m(rd0), .i_regwrite_m(rw0), .i_stall(st0), .i_flush(fl0),
    .o_valid_w(ov0), .o_regwrite_w(orw0), .o_rd_w(ord0), .o_result_w(ores0),
    .o_misaligned_w(omis0), .o_instret(ocnt0));

  writeback_stage #(.P_WIDTH(64), .P_PC_WIDTH(10), .P_CNT_WIDTH(3)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_m(v1), .i_alu_result_m(alu1),
    .i_mem_data_m(mem1), .i_pc_plus_4_m(pc1), .i_imm_m(imm1), .i_resultsrc_m(src1),
    .i_funct3_m(f31), .i_rd_m(rd1), .i_regwrite_m(rw1), .i_stall(st1), .i_flush(fl1),
    .o_valid_w(ov1), .o_regwrite_w(orw1), .o_rd_w(ord1), .o_result_w(ores1),
    .o_misaligned_w(omis1), .o_instret(ocnt1));

  int n_cmp = 0, n_fail = 0;
  op_t         w_op [2];
  logic        w_valid [2];
  logic [63:0] cnt [2];
  op_t         zop;
  vec_t        tbl [14];

  function automatic op_t mk(logic [63:0] alu, mem, pc, imm, logic [1:0] src, logic [2:0] f3,
                             logic [4:0] rd, logic rw);
    op_t o;
    o.alu = alu; o.mem = mem; o.pc = pc; o.imm = imm;
    o.src = src; o.f3 = f3; o.rd = rd; o.rw = rw;
    return o;
  endfunction

  // Reference: access size from funct3, value = aligned lane of the word, then extended.
  function automatic void ref_op(input int d, input op_t o, output logic [63:0] res, output logic mis);
    int w, size, lane;
    logic [63:0] mem, v, mask;
    w   = d ? 64 : 32;
    mem = d ? o.mem : {32'd0, o.mem[31:0]};
    case (o.f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      3'd6:       size = (w == 64) ? 4 : 0;
      3'd3:       size = (w == 64) ? 8 : 0;
      default:    size = 0;
    endcase
    mis = o.src == 2'd1 && size > 1 && (int'(o.alu[7:0]) % size) != 0;
    v = mem;
    if (size > 0 && size < 8) begin
      lane = (int'(o.alu[7:0]) % (w / 8)) / size * size;
      v    = mem >> (8 * lane);
      mask = (64'd1 << (8 * size)) - 64'd1;
      v    = v & mask;
      if (!o.f3[2] && v[8*size-1]) v = v | ~mask;
    end
    case (o.src)
      2'd0:    res = o.alu;
      2'd1:    res = v;
      2'd2:    res = {54'd0, o.pc[9:0]};
      default: res = o.imm;
    endcase
    if (w == 32) res[63:32] = 32'd0;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input int d);
    logic [63:0] r;
    logic m, em, erw;
    ref_op(d, w_op[d], r, m);
    em  = w_valid[d] && m;
    erw = w_valid[d] && w_op[d].rw && w_op[d].rd != 5'd0 && !em;
    if (d == 0) begin
      cmp("valid32", 64'(ov0), 64'(w_valid[0]));
      cmp("regwrite32", 64'(orw0), 64'(erw));
      cmp("misaligned32", 64'(omis0), 64'(em));
      if (w_valid[0]) cmp("rd32", 64'(ord0), 64'(w_op[0].rd));
      if (w_valid[0] && !em) cmp("result32", 64'(ores0), r);
      cmp("instret32", 64'(ocnt0), cnt[0] & 64'hFFFF_FFFF);
    end else begin
      cmp("valid64", 64'(ov1), 64'(w_valid[1]));
      cmp("regwrite64", 64'(orw1), 64'(erw));
      cmp("misaligned64", 64'(omis1), 64'(em));
      if (w_valid[1]) cmp("rd64", 64'(ord1), 64'(w_op[1].rd));
      if (w_valid[1] && !em) cmp("result64", ores1, r);
      cmp("instret64", 64'(ocnt1), cnt[1] & 64'h7);
    end
  endtask

  task automatic drive(input int d, input op_t o, input logic v, st, fl);
    if (d == 0) begin
      v0 = v; alu0 = o.alu[31:0]; mem0 = o.mem[31:0]; pc0 = o.pc[9:0]; imm0 = o.imm[31:0];
      src0 = o.src; f30 = o.f3; rd0 = o.rd; rw0 = o.rw; st0 = st; fl0 = fl;
    end else begin
      v1 = v; alu1 = o.alu; mem1 = o.mem; pc1 = o.pc[9:0]; imm1 = o.imm;
      src1 = o.src; f31 = o.f3; rd1 = o.rd; rw1 = o.rw; st1 = st; fl1 = fl;
    end
  endtask

  task automatic upd(input int d, input op_t o, input logic v, st, fl);
    logic [63:0] r;
    logic m;
    ref_op(d, w_op[d], r, m);
    if (w_valid[d] && !st && !fl && !m) cnt[d]++;
    if (fl) w_valid[d] = 1'b0;
    else if (!st) begin
      w_valid[d] = v;
      w_op[d]    = o;
    end
  endtask

  task automatic step(input int d, input op_t o, input logic v, st, fl);
    drive(d, o, v, st, fl);
    drive(1 - d, zop, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    upd(d, o, v, st, fl);
    upd(1 - d, zop, 1'b0, 1'b0, 1'b0);
    #1;
    check(0);
    check(1);
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      w_valid[d] = 1'b0;
      w_op[d]    = zop;
      cnt[d]     = 64'd0;
    end
  endtask

  function automatic op_t rand_op(input int d);
    op_t o;
    logic [2:0] f32_set [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] f64_set [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    o.alu = {$urandom, $urandom};
    o.mem = {$urandom, $urandom};
    o.pc  = 64'($urandom_range(0, 1023));
    o.imm = {$urandom, $urandom};
    o.src = 2'($urandom_range(0, 3));
    o.f3  = d ? f64_set[$urandom_range(0, 6)] : f32_set[$urandom_range(0, 4)];
    o.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    o.rw  = 1'($urandom_range(0, 1));
    return o;
  endfunction

  initial begin
    logic [63:0] c;
    op_t a, b;
    zop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mreset();
    tbl[0]  = '{0, mk(64'h100, 64'h8090A0FF, 0, 0, 2'd1, 3'd0, 5'd1, 1), 64'hFFFF_FFFF, 0};
    tbl[1]  = '{0, mk(64'h101, 64'h8090A0FF, 0, 0, 2'd1, 3'd4, 5'd2, 1), 64'h0000_00A0, 0};
    tbl[2]  = '{0, mk(64'h102, 64'h8090A0FF, 0, 0, 2'd1, 3'd1, 5'd3, 1), 64'hFFFF_8090, 0};
    tbl[3]  = '{0, mk(64'h100, 64'h8090A0FF, 0, 0, 2'd1, 3'd5, 5'd4, 1), 64'h0000_A0FF, 0};
    tbl[4]  = '{0, mk(64'h100, 64'h8090A0FF, 0, 0, 2'd1, 3'd2, 5'd5, 1), 64'h8090_A0FF, 0};
    tbl[5]  = '{0, mk(64'h102, 64'h8090A0FF, 0, 0, 2'd1, 3'd2, 5'd6, 1), 64'h0, 1};
    tbl[6]  = '{0, mk(64'h103, 64'h8090A0FF, 0, 0, 2'd1, 3'd1, 5'd7, 1), 64'h0, 1};
    tbl[7]  = '{0, mk(64'h0, 0, 64'h3FC, 0, 2'd2, 3'd0, 5'd1, 1), 64'h0000_03FC, 0};
    tbl[8]  = '{0, mk(64'h0, 0, 0, 64'hABCDE000, 2'd3, 3'd0, 5'd2, 1), 64'hABCD_E000, 0};
    tbl[9]  = '{0, mk(64'h55, 0, 0, 0, 2'd0, 3'd0, 5'd0, 1), 64'h55, 0};
    tbl[10] = '{1, mk(64'h4, 64'hF000_0000_8000_0001, 0, 0, 2'd1, 3'd6, 5'd1, 1), 64'h0000_0000_F000_0000, 0};
    tbl[11] = '{1, mk(64'h0, 64'hF000_0000_8000_0001, 0, 0, 2'd1, 3'd2, 5'd2, 1), 64'hFFFF_FFFF_8000_0001, 0};
    tbl[12] = '{1, mk(64'h4, 64'hF000_0000_8000_0001, 0, 0, 2'd1, 3'd3, 5'd3, 1), 64'h0, 1};
    tbl[13] = '{1, mk(64'h0, 64'hF000_0000_8000_0001, 0, 0, 2'd1, 3'd3, 5'd4, 1), 64'hF000_0000_8000_0001, 0};

    repeat (2) @(posedge clk);
    #1;
    check(0);
    check(1);
    cmp("reset_result32", 64'(ores0), 64'd0);
    cmp("reset_result64", ores1, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].d, tbl[i].op, 1'b1, 1'b0, 1'b0);
      cmp("tbl_mis", tbl[i].d ? 64'(omis1) : 64'(omis0), 64'(tbl[i].mis));
      if (!tbl[i].mis) cmp("tbl_res", tbl[i].d ? ores1 : 64'(ores0), tbl[i].res);
    end

    step(0, mk(64'h77, 0, 0, 0, 0, 0, 5'd9, 1), 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    mreset();
    check(0);
    check(1);
    cmp("async_reset_res", 64'(ores0), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, mk(64'h1234, 0, 0, 0, 0, 0, 5'd5, 1), 1'b1, 1'b0, 1'b0);
    cmp("post_reset_res", 64'(ores0), 64'h1234);
    cmp("post_reset_rw", 64'(orw0), 64'd1);
    cmp("post_reset_cnt0", 64'(ocnt0), 64'd0);
    step(0, zop, 1'b0, 1'b0, 1'b0);
    cmp("post_reset_cnt1", 64'(ocnt0), 64'd1);

    a = mk(64'h1111, 0, 0, 0, 0, 0, 5'd3, 1);
    b = mk(64'h2222, 0, 0, 0, 0, 0, 5'd4, 1);
    step(0, a, 1'b1, 1'b0, 1'b0);
    c = 64'(ocnt0);
    for (int i = 0; i < 3; i++) begin
      step(0, b, 1'b1, 1'b1, 1'b0);
      cmp("stall_res", 64'(ores0), 64'h1111);
      cmp("stall_cnt", 64'(ocnt0), c);
    end
    step(0, b, 1'b1, 1'b0, 1'b0);
    cmp("unstall_res", 64'(ores0), 64'h2222);
    cmp("unstall_cnt", 64'(ocnt0), c + 64'd1);

    step(0, a, 1'b1, 1'b0, 1'b0);
    c = 64'(ocnt0);
    step(0, b, 1'b1, 1'b1, 1'b1);
    cmp("flush_valid", 64'(ov0), 64'd0);
    cmp("flush_cnt", 64'(ocnt0), c);
    step(0, zop, 1'b0, 1'b0, 1'b0);
    cmp("flush_bubble_cnt", 64'(ocnt0), c);

    step(1, mk(64'h9, 0, 0, 0, 0, 0, 5'd1, 1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8 && (cnt[1] & 64'h7) != 64'h7; i++)
      step(1, mk(64'h9, 0, 0, 0, 0, 0, 5'd1, 1), 1'b1, 1'b0, 1'b0);
    cmp("pre_wrap_cnt", 64'(ocnt1), 64'h7);
    step(1, mk(64'hA, 0, 0, 0, 0, 0, 5'd1, 1), 1'b1, 1'b0, 1'b0);
    cmp("wrap_cnt", 64'(ocnt1), 64'd0);

    for (int i = 0; i < 400; i++) begin
      int d;
      d = $urandom_range(0, 1);
      step(d, rand_op(d), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
